// File: rtl/m_axis_kernel_serializer_if.sv
// m_axis_kernel_serializer_if: kernel load handshake plus AXI4-Stream master bus.
// master is the serializer's view, slave is the source/sink view.
interface m_axis_kernel_serializer_if #(
    parameter int DATA_WIDTH       = 8,
    parameter int IMAGE_KERNEL_12K = 64
);
    logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] i_image_kernel;
    logic                                        i_kernel_valid;
    logic                                        i_kernel_sof;
    logic                                        o_kernel_ready;
    logic [DATA_WIDTH-1:0]                       o_axis_tdata;
    logic                                        o_axis_tvalid;
    logic                                        i_axis_tready;
    logic                                        o_axis_tuser;
    logic                                        o_axis_tlast;
    modport master (
        input  i_image_kernel, i_kernel_valid, i_kernel_sof, i_axis_tready,
        output o_kernel_ready, o_axis_tdata, o_axis_tvalid, o_axis_tuser, o_axis_tlast
    );
    modport slave (
        output i_image_kernel, i_kernel_valid, i_kernel_sof, i_axis_tready,
        input  o_kernel_ready, o_axis_tdata, o_axis_tvalid, o_axis_tuser, o_axis_tlast
    );
endinterface

// File: rtl/m_axis_kernel_serializer.sv
// m_axis_kernel_serializer: serialises parallel kernels onto an AXI4-Stream master, pixel 0 first.
// Define M_AXIS_KERNEL_SERIALIZER_TLAST_EN to build the kernel counter that drives tlast.
module m_axis_kernel_serializer #(
    parameter int DATA_WIDTH       = 8,
    parameter int IMAGE_KERNEL_12K = 64,
    parameter int KERNELS_PER_LINE = 192
) (
    input  logic                      i_clk,
    input  logic                      i_aresetn,
    m_axis_kernel_serializer_if.master axis
);
    localparam int CW = $clog2(IMAGE_KERNEL_12K);

    if (IMAGE_KERNEL_12K < 2 || KERNELS_PER_LINE < 1) begin : g_bad_cfg
        $error("m_axis_kernel_serializer: IMAGE_KERNEL_12K must be >= 2 and KERNELS_PER_LINE >= 1");
    end

    typedef enum logic {IDLE, SEND} state_t;
    state_t state_q, state_d;
    logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] buf_q;
    logic [CW-1:0] pix_q;
    logic sof_q, beat, last_pix, last_beat, ready, load;

    assign beat      = (state_q == SEND) && axis.i_axis_tready;
    assign last_pix  = pix_q == CW'(IMAGE_KERNEL_12K - 1);
    assign last_beat = beat && last_pix;
    // ready looks through tready so the next kernel loads on the final beat without a bubble
    assign ready     = (state_q == IDLE) || last_beat;
    assign load      = axis.i_kernel_valid && ready;

    always_ff @(posedge i_clk or negedge i_aresetn)
        if (!i_aresetn) state_q <= IDLE;
        else state_q <= state_d;

    always_comb state_d = load ? SEND : last_beat ? IDLE : state_q;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            buf_q <= '0;
            pix_q <= '0;
            sof_q <= 1'b0;
        end else if (load) begin
            buf_q <= axis.i_image_kernel;
            pix_q <= '0;
            sof_q <= axis.i_kernel_sof;
        end else if (beat) begin
            buf_q <= {buf_q[1:IMAGE_KERNEL_12K-1], DATA_WIDTH'(0)};
            pix_q <= pix_q + CW'(1);
        end
    end

    assign axis.o_kernel_ready = ready;
    assign axis.o_axis_tvalid  = state_q == SEND;
    assign axis.o_axis_tdata   = buf_q[0];
    assign axis.o_axis_tuser   = (state_q == SEND) && sof_q && (pix_q == '0);

`ifdef M_AXIS_KERNEL_SERIALIZER_TLAST_EN
    localparam int KW = KERNELS_PER_LINE > 1 ? $clog2(KERNELS_PER_LINE) : 1;
    logic [KW-1:0] kcnt_q, kcnt_inc;

    assign kcnt_inc = (kcnt_q == KW'(KERNELS_PER_LINE - 1)) ? '0 : kcnt_q + KW'(1);

    // kcnt_q is the index of the kernel in the buffer; a sof load restarts the line
    always_ff @(posedge i_clk or negedge i_aresetn)
        if (!i_aresetn) kcnt_q <= '0;
        else if (load) kcnt_q <= axis.i_kernel_sof ? '0 : last_beat ? kcnt_inc : kcnt_q;
        else if (last_beat) kcnt_q <= kcnt_inc;

    assign axis.o_axis_tlast = (state_q == SEND) && last_pix && (kcnt_q == KW'(KERNELS_PER_LINE - 1));
`else
    assign axis.o_axis_tlast = 1'b0;
`endif
endmodule

// File: tb/tb_m_axis_kernel_serializer.sv
// tb_m_axis_kernel_serializer: table-driven kernels plus hand-written corner sequences,
// with a beat scoreboard fed on each kernel load and drained by the stream monitor.
module tb_m_axis_kernel_serializer;
    localparam int W   = 8;
    localparam int K   = 64;
    localparam int KPL = 3;
`ifdef M_AXIS_KERNEL_SERIALIZER_TLAST_EN
    localparam bit TLAST = 1'b1;
`else
    localparam bit TLAST = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         user;
        logic         last;
    } beat_t;

    typedef struct {
        logic [W-1:0] base;
        logic         sof;
        int           mode;
        int           span;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    beat_t exp_q[$];
    vec_t  vecs[5];
    int checks = 0, errors = 0, beats = 0;
    int cyc = 0, first_beat = -1, last_beat = -1, mode = 0, next_kidx = 0;
    logic [W-1:0] ld_tdata;

    m_axis_kernel_serializer_if #(.DATA_WIDTH(W), .IMAGE_KERNEL_12K(K)) axis ();

    m_axis_kernel_serializer #(
        .DATA_WIDTH(W), .IMAGE_KERNEL_12K(K), .KERNELS_PER_LINE(KPL)
    ) dut (
        .i_clk(clk),
        .i_aresetn(rst_n),
        .axis(axis)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // sink back-pressure: 0 always ready, 1 toggle, 2 random, else held low
    initial begin
        axis.i_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: axis.i_axis_tready = 1'b1;
                1: axis.i_axis_tready = ~axis.i_axis_tready;
                2: axis.i_axis_tready = 1'($urandom_range(0, 1));
                default: axis.i_axis_tready = 1'b0;
            endcase
        end
    end

    // monitor: scoreboard compare on handshakes, stability check on stalled beats
    initial begin
        logic  stall;
        beat_t held, e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) stall = 1'b0;
            else begin
                if (stall)
                    check("stall_hold", {axis.o_axis_tvalid, axis.o_axis_tdata, axis.o_axis_tuser, axis.o_axis_tlast},
                          {1'b1, held});
                if (axis.o_axis_tvalid && axis.i_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h with empty scoreboard", axis.o_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {axis.o_axis_tdata, axis.o_axis_tuser, axis.o_axis_tlast}, e);
                    end
                    beats++;
                    if (first_beat < 0) first_beat = cyc;
                    last_beat = cyc;
                end
                stall = axis.o_axis_tvalid && !axis.i_axis_tready;
                held  = {axis.o_axis_tdata, axis.o_axis_tuser, axis.o_axis_tlast};
            end
        end
    end

    task automatic wait_load(input logic [W-1:0] base, input logic sof, input bit keep);
        int n = 0;
        int kidx;
        do begin
            @(negedge clk);
            n++;
        end while (!axis.o_kernel_ready && n < 2000);
        if (!axis.o_kernel_ready) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: kernel %0h not accepted within %0d cycles", base, n);
            return;
        end
        ld_tdata  = axis.o_axis_tdata;
        kidx      = sof ? 0 : next_kidx;
        next_kidx = (kidx + 1) % KPL;
        for (int i = 0; i < K; i++)
            exp_q.push_back({base + W'(i), sof && i == 0, TLAST && kidx == KPL - 1 && i == K - 1});
        @(posedge clk);
        #1;
        if (!keep) begin
            axis.i_kernel_valid = 1'b0;
            axis.i_kernel_sof   = 1'b0;
        end
        @(negedge clk);
        check("latency", {axis.o_axis_tvalid, axis.o_axis_tdata, axis.o_axis_tuser}, {1'b1, base, sof});
    endtask

    task automatic drive_kernel(input logic [W-1:0] base, input logic sof);
        @(posedge clk);
        #1;
        for (int i = 0; i < K; i++) axis.i_image_kernel[i] = base + W'(i);
        axis.i_kernel_valid = 1'b1;
        axis.i_kernel_sof   = sof;
    endtask

    task automatic send_kernel(input logic [W-1:0] base, input logic sof, input bit keep);
        drive_kernel(base, sof);
        wait_load(base, sof, keep);
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 3000);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check("idle_after", {axis.o_axis_tvalid, axis.o_kernel_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        axis.i_image_kernel = '0;
        axis.i_kernel_valid = 1'b0;
        axis.i_kernel_sof   = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        check("reset_out", {axis.o_axis_tvalid, axis.o_axis_tdata, axis.o_axis_tuser, axis.o_axis_tlast,
                            axis.o_kernel_ready}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        #11 rst_n = 1'b1;

        vecs[0] = '{8'h00, 1'b1, 0, 64};
        vecs[1] = '{8'h00, 1'b1, 1, 127};
        vecs[2] = '{8'hA0, 1'b0, 0, 64};
        vecs[3] = '{8'h37, 1'b0, 2, -1};
        vecs[4] = '{8'h10, 1'b1, 1, 127};
        for (int v = 0; v < 5; v++) begin
            mode       = vecs[v].mode;
            first_beat = -1;
            send_kernel(vecs[v].base, vecs[v].sof, 1'b0);
            wait_drain();
            if (vecs[v].span >= 0) check("span", 32'(last_beat - first_beat + 1), 32'(vecs[v].span));
        end

        // back-to-back kernels: no bubble, next load on A's last beat
        mode       = 0;
        first_beat = -1;
        send_kernel(8'd0, 1'b1, 1'b1);
        send_kernel(8'd100, 1'b0, 1'b0);
        check("b2b_load_on_beat63", ld_tdata, 8'd63);
        wait_drain();
        check("b2b_span", 32'(last_beat - first_beat + 1), 32'd128);

        // one line of KPL kernels, then a new frame
        first_beat = -1;
        send_kernel(8'h00, 1'b1, 1'b1);
        send_kernel(8'h40, 1'b0, 1'b1);
        send_kernel(8'h80, 1'b0, 1'b1);
        send_kernel(8'hC0, 1'b1, 1'b0);
        wait_drain();
        check("line_span", 32'(last_beat - first_beat + 1), 32'd256);

        // asynchronous reset in the middle of a kernel
        send_kernel(8'h30, 1'b1, 1'b0);
        begin
            int b0, n;
            b0 = beats - 1;
            n  = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (beats < b0 + 20 && n < 200);
            check("reset_reach_beat20", 32'(beats - b0), 32'd20);
        end
        #1 rst_n = 1'b0;
        #1;
        check("reset_mid", {axis.o_axis_tvalid, axis.o_axis_tdata, axis.o_axis_tuser, axis.o_axis_tlast,
                            axis.o_kernel_ready}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        exp_q.delete();
        next_kidx = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        send_kernel(8'h55, 1'b1, 1'b0);
        wait_drain();

        // pending kernel refused under back-pressure, accepted on the last beat
        mode = 3;
        send_kernel(8'h20, 1'b0, 1'b1);
        drive_kernel(8'hE0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reject_ready", {axis.o_kernel_ready, axis.o_axis_tdata}, {1'b0, 8'h20});
        end
        mode = 0;
        wait_load(8'hE0, 1'b1, 1'b0);
        check("accept_on_last", ld_tdata, 8'h5F);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
